// File: rtl/key_pkg.sv
// Shared definitions for the key debounce / one-hot front end.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: none; the front end is a free-running sampled path.
package key_pkg;

    localparam int NKEYS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } arb_state_t;

    // Number of debounced keys currently down.
    function automatic logic [2:0] popcount_keys(input logic [NKEYS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NKEYS; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/key_debounce_onehot_if.sv
// Key front-end signal bundle: raw button lines in, clean one-hot code out.
// Latency: n/a (wires only).
// Backpressure: none; outputs are level/pulse signals sampled by the consumer.
// Ports: key_raw (4, raw buttons), key_onehot (4), key_valid, key_strobe, multi_err.
interface key_debounce_onehot_if;

    logic [key_pkg::NKEYS-1:0] key_raw;
    logic [key_pkg::NKEYS-1:0] key_onehot;
    logic                      key_valid;
    logic                      key_strobe;
    logic                      multi_err;

    // master drives the buttons and observes the code (board / bench side)
    modport master (
        output key_raw,
        input  key_onehot, key_valid, key_strobe, multi_err
    );

    // slave is the debounce block itself
    modport slave (
        input  key_raw,
        output key_onehot, key_valid, key_strobe, multi_err
    );

endinterface

// File: rtl/debounce_cell.sv
// One-bit synchroniser plus debounce filter producing a stable level.
// Latency: 2 sync clocks + DEBOUNCE_CYCLES stable samples to move lvl.
// Backpressure: none; samples every clock.
// Ports: clk, rst (async active-high), din (raw async button), lvl (debounced).
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // Plain two-flop chain, nothing between the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    // cnt holds how many consecutive samples have disagreed with lvl, minus
    // one; any agreeing sample restarts it, so short glitches never land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= 1'b0;
            cnt <= '0;
        end else if (sync_q2 == lvl) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            lvl <= sync_q2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/key_debounce_onehot.sv
// Debounces four push buttons and emits a registered one-hot key code or zero.
// Latency: DEBOUNCE_CYCLES+3 clocks from a clean raw edge to key_onehot/strobe.
// Backpressure: none; multi-key presses collapse to zero with multi_err set.
// Ports: clk, rst (async active-high), kif (slave: key_raw in, code/flags out).
module key_debounce_onehot
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    key_debounce_onehot_if.slave kif
);

    logic [NKEYS-1:0] lvl;
    logic [2:0]       lvl_cnt;

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [NKEYS-1:0] onehot_q;
    logic [NKEYS-1:0] onehot_nxt;
    logic             strobe_q;
    logic             strobe_nxt;

    for (genvar i = 0; i < NKEYS; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .din (kif.key_raw[i]),
            .lvl (lvl[i])
        );
    end

    assign lvl_cnt = popcount_keys(lvl);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            onehot_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            onehot_q <= onehot_nxt;
            strobe_q <= strobe_nxt;
        end
    end

    // A key is accepted only from IDLE, so a swap between keys always goes
    // through MULTI and needs a full release before the next press counts.
    always_comb begin
        state_nxt  = state;
        onehot_nxt = onehot_q;
        strobe_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                onehot_nxt = '0;
                if (lvl_cnt == 3'd1) begin
                    state_nxt  = ONE;
                    onehot_nxt = lvl;
                    strobe_nxt = 1'b1;
                end else if (lvl_cnt >= 3'd2) begin
                    state_nxt = MULTI;
                end
            end
            ONE: begin
                if (lvl == '0) begin
                    state_nxt  = IDLE;
                    onehot_nxt = '0;
                end else if (lvl != onehot_q) begin
                    state_nxt  = MULTI;
                    onehot_nxt = '0;
                end
            end
            MULTI: begin
                onehot_nxt = '0;
                if (lvl == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                onehot_nxt = '0;
            end
        endcase
    end

    assign kif.key_onehot = onehot_q;
    assign kif.key_valid  = |onehot_q;
    assign kif.key_strobe = strobe_q;
    assign kif.multi_err  = (state == MULTI);

endmodule
